// File: rtl/mdu_if.sv
// Handshake bundle between the issuing stage and the multiply/divide sequencer.
`timescale 1ns/1ps
interface mdu_if;
  logic [3:0]  mul_func;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        rd_hilo;
  logic        flush;
  logic        stall;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output mul_func, op_a, op_b, rd_hilo, flush,
    input  stall, busy, hi, lo
  );

  modport slave (
    input  mul_func, op_a, op_b, rd_hilo, flush,
    output stall, busy, hi, lo
  );
endinterface

// File: rtl/mdu_sequencer.sv
// Fixed-latency multiply/divide sequencer owning the HI/LO pair; stalls the
// issuing stage while an operation is in flight.
`timescale 1ns/1ps
module mdu_sequencer #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input logic   clk,
  input logic   rst,
  mdu_if.slave  bus
);
  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [3:0] F_MULT  = 4'd1;
  localparam logic [3:0] F_MULTU = 4'd2;
  localparam logic [3:0] F_DIV   = 4'd3;
  localparam logic [3:0] F_DIVU  = 4'd4;
  localparam logic [3:0] F_SETHI = 4'd5;
  localparam logic [3:0] F_SETLO = 4'd6;
  localparam logic [3:0] F_MADD  = 4'd7;
  localparam logic [3:0] F_MADDU = 4'd8;
  localparam logic [3:0] F_MSUB  = 4'd9;
  localparam logic [3:0] F_MSUBU = 4'd10;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               busy_r;
  logic [31:0]        hi_r;
  logic [31:0]        lo_r;
  logic [3:0]         op_p0;
  logic [31:0]        a_p0;
  logic [31:0]        b_p0;
  logic [63:0]        res_p1;
  logic               res_ok_p1;
  logic               is_mdu_op;
  logic               is_long_op;
  logic               accept;

  // 64-bit product; operands are sign- or zero-extended before multiplying.
  function automatic logic [63:0] mul_64(input logic [31:0] a, input logic [31:0] b,
                                         input logic sgn);
    logic signed [63:0] ea;
    logic signed [63:0] eb;
    ea = sgn ? $signed({{32{a[31]}}, a}) : $signed({32'd0, a});
    eb = sgn ? $signed({{32{b[31]}}, b}) : $signed({32'd0, b});
    return ea * eb;
  endfunction

  // Returns {remainder, quotient}. Signed division works on magnitudes so the
  // 0x80000000 / -1 overflow case falls out naturally as 0x80000000 rem 0.
  function automatic logic [63:0] div_64(input logic [31:0] a, input logic [31:0] b,
                                         input logic sgn);
    logic [31:0] ma;
    logic [31:0] mb;
    logic [31:0] q;
    logic [31:0] r;
    logic        neg_q;
    logic        neg_r;
    neg_r = sgn & a[31];
    neg_q = sgn & (a[31] ^ b[31]);
    ma    = neg_r ? -a : a;
    mb    = (sgn & b[31]) ? -b : b;
    q     = ma / mb;
    r     = ma % mb;
    return {(neg_r ? -r : r), (neg_q ? -q : q)};
  endfunction

  always_comb begin
    is_mdu_op  = (bus.mul_func >= F_MULT) && (bus.mul_func <= F_MSUBU);
    is_long_op = is_mdu_op && (bus.mul_func != F_SETHI) && (bus.mul_func != F_SETLO);
    accept     = (state == IDLE) && !bus.flush && is_long_op;
  end

  // Commit value, evaluated against the latched operands and the live HI/LO.
  always_comb begin
    res_p1    = {hi_r, lo_r};
    res_ok_p1 = 1'b1;
    case (op_p0)
      F_MULT:  res_p1 = mul_64(a_p0, b_p0, 1'b1);
      F_MULTU: res_p1 = mul_64(a_p0, b_p0, 1'b0);
      F_DIV: begin
        res_p1    = div_64(a_p0, b_p0, 1'b1);
        res_ok_p1 = |b_p0;
      end
      F_DIVU: begin
        res_p1    = div_64(a_p0, b_p0, 1'b0);
        res_ok_p1 = |b_p0;
      end
      F_MADD:  res_p1 = {hi_r, lo_r} + mul_64(a_p0, b_p0, 1'b1);
      F_MADDU: res_p1 = {hi_r, lo_r} + mul_64(a_p0, b_p0, 1'b0);
      F_MSUB:  res_p1 = {hi_r, lo_r} - mul_64(a_p0, b_p0, 1'b1);
      F_MSUBU: res_p1 = {hi_r, lo_r} - mul_64(a_p0, b_p0, 1'b0);
      default: ;
    endcase
  end

  // Stage p0: operand capture on acceptance.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_p0 <= bus.mul_func;
      a_p0  <= bus.op_a;
      b_p0  <= bus.op_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      busy_r <= 1'b0;
      hi_r   <= '0;
      lo_r   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!bus.flush) begin
            if (bus.mul_func == F_SETHI) hi_r <= bus.op_a;
            if (bus.mul_func == F_SETLO) lo_r <= bus.op_a;
            if (is_long_op) begin
              state  <= RUN;
              busy_r <= 1'b1;
              cnt    <= ((bus.mul_func == F_DIV) || (bus.mul_func == F_DIVU)) ?
                        CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
            end
          end
        end
        RUN: begin
          if (bus.flush) begin
            state  <= IDLE;
            busy_r <= 1'b0;
            cnt    <= '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
            // Stage p1: commit on the final counted edge.
            if (cnt == CNT_W'(1)) begin
              if (res_ok_p1) {hi_r, lo_r} <= res_p1;
              state  <= IDLE;
              busy_r <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.stall = busy_r & (is_mdu_op | bus.rd_hilo);
  assign bus.busy  = busy_r;
  assign bus.hi    = hi_r;
  assign bus.lo    = lo_r;
endmodule

// File: tb/tb_mdu_sequencer.sv
// Bench for mdu_sequencer: vector table, directed corner sequences and
// randomized traffic against a cycle-level reference model.
`timescale 1ns/1ps
module tb_mdu_sequencer;
  localparam int MUL_N = 5;
  localparam int DIV_N = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mdu_if bus();

  mdu_sequencer #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  logic [31:0] m_hi, m_lo, m_a, m_b;
  logic [3:0]  m_op;
  bit          m_busy;
  int          m_left;

  typedef struct {
    logic [3:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;
  vec_t vt[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_long(input logic [3:0] f);
    return (f >= 4'd1 && f <= 4'd4) || (f >= 4'd7 && f <= 4'd10);
  endfunction

  function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [63:0] acc);
    longint sa, sb, q, r;
    logic [63:0] ua, ub, sp, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    sp = sa * sb;
    up = ua * ub;
    case (op)
      4'd1:  return sp;
      4'd2:  return up;
      4'd3: begin
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      4'd4:  return {32'(ua % ub), 32'(ua / ub)};
      4'd7:  return acc + sp;
      4'd8:  return acc + up;
      4'd9:  return acc - sp;
      4'd10: return acc - up;
      default: return acc;
    endcase
  endfunction

  task automatic model_reset();
    m_hi = '0; m_lo = '0; m_busy = 0; m_left = 0;
  endtask

  task automatic model_edge(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                            input logic fl);
    if (m_busy) begin
      if (fl) m_busy = 0;
      else begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 0;
          if (!((m_op == 4'd3 || m_op == 4'd4) && m_b == 0))
            {m_hi, m_lo} = ref_result(m_op, m_a, m_b, {m_hi, m_lo});
        end
      end
    end else if (!fl) begin
      if (f == 4'd5) m_hi = a;
      else if (f == 4'd6) m_lo = a;
      else if (is_long(f)) begin
        m_busy = 1;
        m_left = (f == 4'd3 || f == 4'd4) ? DIV_N : MUL_N;
        m_op = f; m_a = a; m_b = b;
      end
    end
  endtask

  // One clock: drive, check stall, take the edge, check registered outputs.
  task automatic cycle(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic rd, input logic fl);
    bus.mul_func = f; bus.op_a = a; bus.op_b = b; bus.rd_hilo = rd; bus.flush = fl;
    #1;
    check("stall", bus.stall, m_busy && ((f >= 4'd1 && f <= 4'd10) || rd));
    @(posedge clk);
    model_edge(f, a, b, fl);
    #1;
    check("busy", bus.busy, m_busy);
    check("hi", bus.hi, m_hi);
    check("lo", bus.lo, m_lo);
  endtask

  task automatic drain(output int nb);
    nb = 0;
    while (bus.busy && nb < 40) begin
      cycle(4'd0, 32'd0, 32'd0, 1'b1, 1'b0);
      nb++;
    end
  endtask

  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_busy", bus.busy, 1'b0);
    check("rst_hi", bus.hi, 32'd0);
    check("rst_lo", bus.lo, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int nb;
    logic [31:0] sh, sl;
    vt[0] = '{4'd1, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA};
    vt[1] = '{4'd2, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'hFFFFFFFA};
    vt[2] = '{4'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vt[3] = '{4'd4, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003};
    vt[4] = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vt[5] = '{4'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vt[6] = '{4'd3, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vt[7] = '{4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};

    bus.mul_func = '0; bus.op_a = '0; bus.op_b = '0; bus.rd_hilo = 1'b0; bus.flush = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", bus.busy, 1'b0);
    check("reset_stall", bus.stall, 1'b0);
    check("reset_hi", bus.hi, 32'd0);
    check("reset_lo", bus.lo, 32'd0);
    rst = 1'b0;

    // Vector table: latency and result per operation
    for (int i = 0; i < 8; i++) begin
      cycle(vt[i].f, vt[i].a, vt[i].b, 1'b1, 1'b0);
      drain(nb);
      check($sformatf("vec%0d_latency", i), nb, (vt[i].f == 4'd3 || vt[i].f == 4'd4) ? DIV_N : MUL_N);
      check($sformatf("vec%0d_hi", i), bus.hi, vt[i].hi);
      check($sformatf("vec%0d_lo", i), bus.lo, vt[i].lo);
    end

    // SetHI / SetLO back to back, then MADD
    cycle(4'd5, 32'h12345678, 32'd0, 1'b0, 1'b0);
    check("sethi", bus.hi, 32'h12345678);
    check("sethi_busy", bus.busy, 1'b0);
    cycle(4'd6, 32'h00000009, 32'd0, 1'b0, 1'b0);
    check("setlo", bus.lo, 32'h00000009);
    check("setlo_busy", bus.busy, 1'b0);
    cycle(4'd7, 32'd2, 32'd3, 1'b0, 1'b0);
    drain(nb);
    check("madd", {bus.hi, bus.lo}, 64'h12345678_0000000F);

    // Divide by zero keeps HI/LO
    cycle(4'd6, 32'h000000AA, 32'd0, 1'b0, 1'b0);
    cycle(4'd4, 32'd5, 32'd0, 1'b0, 1'b0);
    drain(nb);
    check("divz_latency", nb, DIV_N);
    check("divz_lo", bus.lo, 32'h000000AA);
    check("divz_hi", bus.hi, 32'h12345678);

    // Flush in the third RUN cycle
    sh = bus.hi; sl = bus.lo;
    cycle(4'd1, 32'd7, 32'd9, 1'b0, 1'b0);
    cycle(4'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    cycle(4'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    cycle(4'd0, 32'd0, 32'd0, 1'b1, 1'b1);
    check("flush_busy", bus.busy, 1'b0);
    check("flush_hilo", {bus.hi, bus.lo}, {sh, sl});

    // Flush on the commit edge
    cycle(4'd1, 32'd7, 32'd9, 1'b0, 1'b0);
    for (int k = 0; k < MUL_N - 1; k++) cycle(4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    cycle(4'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    check("flush_commit_busy", bus.busy, 1'b0);
    check("flush_commit_hilo", {bus.hi, bus.lo}, {sh, sl});

    // Flush in IDLE suppresses SetHI and acceptance
    cycle(4'd5, 32'hDEADBEEF, 32'd0, 1'b0, 1'b1);
    check("flush_idle_hi", bus.hi, sh);
    cycle(4'd1, 32'd2, 32'd2, 1'b0, 1'b1);
    check("flush_idle_busy", bus.busy, 1'b0);

    // Reset mid-RUN
    cycle(4'd5, 32'h00000055, 32'd0, 1'b0, 1'b0);
    cycle(4'd1, 32'd4, 32'd4, 1'b0, 1'b0);
    cycle(4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    async_reset();

    // Second MULT held while the first runs
    cycle(4'd1, 32'd3, 32'd4, 1'b0, 1'b0);
    nb = 0;
    while (bus.busy && nb < 20) begin
      cycle(4'd1, 32'd5, 32'd6, 1'b0, 1'b0);
      nb++;
    end
    check("b2b_first_latency", nb, MUL_N);
    check("b2b_first", {bus.hi, bus.lo}, 64'd12);
    cycle(4'd1, 32'd5, 32'd6, 1'b0, 1'b0);
    check("b2b_second_accept", bus.busy, 1'b1);
    drain(nb);
    check("b2b_second", {bus.hi, bus.lo}, 64'd30);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [3:0]  f;
      logic [31:0] a, b;
      f = 4'($urandom_range(0, 15));
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      cycle(f, a, b, 1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0));
    end
    drain(nb);
    check("final_idle", bus.busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
